uart_apb_fifo_regs: RTL and testbench

Parametrised successor to the UART APB register block, with a well-defined APB slave handshake (one wait state) and real TX/RX FIFOs of configurable depth. FIFOs track occupancy, full/empty, overrun and programmable RX threshold, and the block generates a single interrupt. It sits between the APB fabric and the UART shift/baud core: the core pulls from the TX FIFO and pushes into the RX FIFO through valid/ready ports.

---
 rtl/uart_apb_fifo_regs.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_apb_fifo_regs.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_fifo_regs.sv
// UART APB register block with TX/RX FIFOs, one-wait-state APB handshake and a single irq.
// Accesses are decoded in WAIT, acknowledged in DONE, and commit on the edge that ends DONE.
module uart_apb_fifo_regs #(
  parameter int unsigned               APB_ADDR_WIDTH = 32,
  parameter int unsigned               APB_DATA_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] UART_REG_BASE  = 32'ha0300000,
  parameter int unsigned               FIFO_DEPTH     = 16,
  parameter int unsigned               FIFO_AW        = 4
) (
  input  logic                      apb_clk_in,
  input  logic                      apb_rst_in,
  input  logic [APB_ADDR_WIDTH-1:0] apb_addr_in,
  input  logic                      apb_psel_in,
  input  logic                      apb_penable_in,
  input  logic                      apb_write_in,
  input  logic [APB_DATA_WIDTH-1:0] apb_wdata_in,
  output logic [APB_DATA_WIDTH-1:0] apb_rdata_out,
  output logic                      apb_ready_out,
  output logic                      apb_slverr_out,
  output logic [7:0]                tx_data_out,
  output logic                      tx_valid_out,
  input  logic                      tx_ready_in,
  input  logic [7:0]                rx_data_in,
  input  logic                      rx_valid_in,
  output logic [15:0]               dlr_out,
  output logic [7:0]                lcr_out,
  output logic                      loop_out,
  output logic                      irq_out
);

  localparam int unsigned CW = FIFO_AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDone} apb_state_e;
  apb_state_e r_state, w_state_next;

  logic [7:0]                r_tx_mem [FIFO_DEPTH];
  logic [7:0]                r_rx_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]        r_tx_wr_ptr, r_tx_rd_ptr, r_rx_wr_ptr, r_rx_rd_ptr;
  logic [CW-1:0]             r_tx_count, r_rx_count;
  logic                      r_overrun;
  logic [2:0]                r_ier;
  logic [1:0]                r_rxthr;
  logic [7:0]                r_lcr;
  logic                      r_loop;
  logic [15:0]               r_dlr;
  logic                      r_irq;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
  logic                      r_slverr;
  logic                      r_acc_write, r_acc_pop;
  logic [2:0]                r_acc_idx;
  logic [15:0]               r_acc_wdata;

  logic       w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic [7:0] w_offset;
  logic       w_base_ok, w_err;
  logic [31:0] w_stat, w_rd_val;
  logic       w_commit, w_wr, w_wr_dr, w_wr_ier, w_wr_fcr, w_wr_lcr, w_wr_dlr, w_wr_stat;
  logic       w_rx_pop, w_tx_pop, w_rx_clr, w_tx_clr, w_rx_push, w_tx_push, w_ovr_set;
  logic [CW-1:0] w_thr;
  logic       w_unused;

  assign w_unused = ^apb_wdata_in[APB_DATA_WIDTH-1:16];

  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) r_state <= StIdle;
    else            r_state <= w_state_next;
  end

  // Dropping psel while waiting abandons the access before anything is latched for commit.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (apb_psel_in && apb_penable_in) w_state_next = StWait;
      StWait:  w_state_next = apb_psel_in ? StDone : StIdle;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  assign w_tx_empty = (r_tx_count == '0);
  assign w_tx_full  = (r_tx_count == DEPTH_C);
  assign w_rx_empty = (r_rx_count == '0);
  assign w_rx_full  = (r_rx_count == DEPTH_C);

  assign w_offset  = apb_addr_in[7:0];
  assign w_base_ok = (apb_addr_in[APB_ADDR_WIDTH-1:8] == UART_REG_BASE[APB_ADDR_WIDTH-1:8]);
  assign w_err     = !w_base_ok || (w_offset > 8'h14) || (w_offset[1:0] != 2'b00) ||
                     (apb_write_in && (w_offset == 8'h00) && w_tx_full);

  always_comb begin
    w_stat            = '0;
    w_stat[0]         = w_rx_empty;
    w_stat[1]         = w_tx_full;
    w_stat[2]         = r_overrun;
    w_stat[3]         = w_tx_empty;
    w_stat[8 +: CW]   = r_rx_count;
    w_stat[16 +: CW]  = r_tx_count;
  end

  always_comb begin
    w_rd_val = '0;
    case (w_offset[4:2])
      3'd0:    w_rd_val = w_rx_empty ? 32'd0 : {24'd0, r_rx_mem[r_rx_rd_ptr]};
      3'd1:    w_rd_val = {29'd0, r_ier};
      3'd2:    w_rd_val = {30'd0, r_rxthr};
      3'd3:    w_rd_val = {23'd0, r_loop, r_lcr};
      3'd4:    w_rd_val = {16'd0, r_dlr};
      3'd5:    w_rd_val = w_stat;
      default: w_rd_val = '0;
    endcase
  end

  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) begin
      r_rdata     <= '0;
      r_slverr    <= 1'b0;
      r_acc_write <= 1'b0;
      r_acc_pop   <= 1'b0;
      r_acc_idx   <= '0;
      r_acc_wdata <= '0;
    end else if (r_state == StWait && apb_psel_in) begin
      r_slverr    <= w_err;
      r_rdata     <= (w_err || apb_write_in) ? '0 : APB_DATA_WIDTH'(w_rd_val);
      r_acc_write <= apb_write_in && !w_err;
      r_acc_pop   <= !apb_write_in && !w_err && (w_offset[4:2] == 3'd0) && !w_rx_empty;
      r_acc_idx   <= w_offset[4:2];
      r_acc_wdata <= apb_wdata_in[15:0];
    end
  end

  assign w_commit  = (r_state == StDone);
  assign w_wr      = w_commit && r_acc_write;
  assign w_wr_dr   = w_wr && (r_acc_idx == 3'd0);
  assign w_wr_ier  = w_wr && (r_acc_idx == 3'd1);
  assign w_wr_fcr  = w_wr && (r_acc_idx == 3'd2);
  assign w_wr_lcr  = w_wr && (r_acc_idx == 3'd3);
  assign w_wr_dlr  = w_wr && (r_acc_idx == 3'd4);
  assign w_wr_stat = w_wr && (r_acc_idx == 3'd5);

  assign w_rx_pop  = w_commit && r_acc_pop && !w_rx_empty;
  assign w_tx_pop  = !w_tx_empty && tx_ready_in;
  assign w_rx_clr  = w_wr_fcr && r_acc_wdata[2];
  assign w_tx_clr  = w_wr_fcr && r_acc_wdata[3];
  assign w_rx_push = rx_valid_in && (!w_rx_full || w_rx_pop);
  assign w_tx_push = w_wr_dr && (!w_tx_full || w_tx_pop);
  assign w_ovr_set = rx_valid_in && w_rx_full && !w_rx_pop && !w_rx_clr;

  always_ff @(posedge apb_clk_in) begin
    if (w_tx_push) r_tx_mem[r_tx_wr_ptr] <= r_acc_wdata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wr_ptr] <= rx_data_in;
  end

  // A flush overrides any push or pop in the same cycle.
  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_tx_clr) begin
        r_tx_wr_ptr <= '0;
        r_tx_rd_ptr <= '0;
        r_tx_count  <= '0;
      end else begin
        if (w_tx_push) r_tx_wr_ptr <= r_tx_wr_ptr + FIFO_AW'(1);
        if (w_tx_pop)  r_tx_rd_ptr <= r_tx_rd_ptr + FIFO_AW'(1);
        r_tx_count <= r_tx_count + CW'(w_tx_push) - CW'(w_tx_pop);
      end
      if (w_rx_clr) begin
        r_rx_wr_ptr <= '0;
        r_rx_rd_ptr <= '0;
        r_rx_count  <= '0;
      end else begin
        if (w_rx_push) r_rx_wr_ptr <= r_rx_wr_ptr + FIFO_AW'(1);
        if (w_rx_pop)  r_rx_rd_ptr <= r_rx_rd_ptr + FIFO_AW'(1);
        r_rx_count <= r_rx_count + CW'(w_rx_push) - CW'(w_rx_pop);
      end
      if (w_ovr_set)                          r_overrun <= 1'b1;
      else if (w_wr_stat && r_acc_wdata[2])   r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) begin
      r_ier   <= '0;
      r_rxthr <= '0;
      r_lcr   <= '0;
      r_loop  <= 1'b0;
      r_dlr   <= 16'd1;
    end else begin
      if (w_wr_ier) r_ier <= r_acc_wdata[2:0];
      if (w_wr_fcr) r_rxthr <= r_acc_wdata[1:0];
      if (w_wr_lcr) begin
        r_lcr  <= {r_acc_wdata[7:1], 1'b0};
        r_loop <= r_acc_wdata[8];
      end
      if (w_wr_dlr) r_dlr <= (r_acc_wdata == 16'd0) ? 16'd1 : r_acc_wdata;
    end
  end

  always_comb begin
    w_thr = CW'(1);
    case (r_rxthr)
      2'd0: w_thr = CW'(1);
      2'd1: w_thr = CW'(FIFO_DEPTH / 4);
      2'd2: w_thr = CW'(FIFO_DEPTH / 2);
      2'd3: w_thr = CW'(FIFO_DEPTH - 2);
    endcase
  end

  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) r_irq <= 1'b0;
    else r_irq <= (r_ier[0] && (r_rx_count >= w_thr)) || (r_ier[1] && w_tx_empty) ||
                  (r_ier[2] && r_overrun);
  end

  assign apb_rdata_out  = r_rdata;
  assign apb_ready_out  = (r_state == StDone);
  assign apb_slverr_out = (r_state == StDone) && r_slverr;
  assign tx_data_out    = r_tx_mem[r_tx_rd_ptr];
  assign tx_valid_out   = !w_tx_empty;
  assign dlr_out        = r_dlr;
  assign lcr_out        = r_lcr;
  assign loop_out       = r_loop;
  assign irq_out        = r_irq;

endmodule

// File: tb/tb_uart_apb_fifo_regs.sv
// Bench for uart_apb_fifo_regs: directed sequence with random data, checked against
// queue-based FIFO and register models.
module tb_uart_apb_fifo_regs;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'ha0300000;
  localparam logic [31:0] A_DR  = BASE + 32'h00;
  localparam logic [31:0] A_IER = BASE + 32'h04;
  localparam logic [31:0] A_FCR = BASE + 32'h08;
  localparam logic [31:0] A_LCR = BASE + 32'h0C;
  localparam logic [31:0] A_DLR = BASE + 32'h10;
  localparam logic [31:0] A_ST  = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [7:0]  tx_data, rx_data, lcr;
  logic        tx_valid, tx_ready, rx_valid, loop_o, irq;
  logic [15:0] dlr;

  always #5 clk = ~clk;

  uart_apb_fifo_regs #(
    .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .UART_REG_BASE(BASE),
    .FIFO_DEPTH(DEPTH), .FIFO_AW(4)
  ) dut (
    .apb_clk_in(clk), .apb_rst_in(rst), .apb_addr_in(paddr), .apb_psel_in(psel),
    .apb_penable_in(penable), .apb_write_in(pwrite), .apb_wdata_in(pwdata),
    .apb_rdata_out(prdata), .apb_ready_out(pready), .apb_slverr_out(pslverr),
    .tx_data_out(tx_data), .tx_valid_out(tx_valid), .tx_ready_in(tx_ready),
    .rx_data_in(rx_data), .rx_valid_in(rx_valid), .dlr_out(dlr), .lcr_out(lcr),
    .loop_out(loop_o), .irq_out(irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  byte unsigned rxq[$];
  byte unsigned txq[$];
  logic [2:0]   m_ier;
  logic [1:0]   m_rxthr;
  logic         m_ovr;

  task automatic m_reset();
    rxq.delete(); txq.delete();
    m_ier = '0; m_rxthr = '0; m_ovr = 1'b0;
  endtask

  function automatic int thr(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return DEPTH / 4;
      2'd2:    return DEPTH / 2;
      default: return DEPTH - 2;
    endcase
  endfunction

  function automatic logic [31:0] m_stat();
    logic [31:0] s;
    s = '0;
    s[0] = (rxq.size() == 0);
    s[1] = (txq.size() == DEPTH);
    s[2] = m_ovr;
    s[3] = (txq.size() == 0);
    s[12:8]  = 5'(rxq.size());
    s[20:16] = 5'(txq.size());
    return s;
  endfunction

  function automatic logic m_irq();
    return (m_ier[0] && (rxq.size() >= thr(m_rxthr))) || (m_ier[1] && (txq.size() == 0)) ||
           (m_ier[2] && m_ovr);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full APB transfer; optional rx push / tx pop ride along with the commit edge.
  task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                     input logic cc_rx, input logic [7:0] cc_b, input logic cc_txpop,
                     output logic [31:0] rdata, output logic err);
    int lows;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata;
    tick();
    penable = 1'b1;
    lows = 0;
    tick();
    while (!pready && lows < 8) begin
      lows++;
      tick();
    end
    chk("apb_ready", 32'(pready), 32'd1);
    chk("apb_wait_states", lows, 1);
    rdata = prdata;
    err   = pslverr;
    if (cc_rx) begin rx_valid = 1'b1; rx_data = cc_b; end
    if (cc_txpop) tx_ready = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
  endtask

  task automatic reg_wr(input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    logic [31:0] rd; logic er;
    apb(addr, 1'b1, wdata, 1'b0, 8'h00, 1'b0, rd, er);
    chk(tag, 32'(er), 32'd0);
  endtask

  task automatic reg_rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] rd; logic er;
    apb(addr, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, rd, er);
    chk(tag, rd, exp);
    chk({tag, "_slverr"}, 32'(er), 32'd0);
  endtask

  task automatic dr_write(input byte unsigned b);
    logic [31:0] rd; logic er; logic exp_err;
    exp_err = (txq.size() == DEPTH);
    apb(A_DR, 1'b1, {24'h0, b}, 1'b0, 8'h00, 1'b0, rd, er);
    chk("dr_write_slverr", 32'(er), 32'(exp_err));
    if (!exp_err) txq.push_back(b);
  endtask

  task automatic dr_read(input logic cc_rx, input byte unsigned cc_b);
    logic [31:0] rd; logic er; logic [31:0] exp;
    exp = (rxq.size() != 0) ? {24'h0, rxq[0]} : 32'h0;
    apb(A_DR, 1'b0, 32'h0, cc_rx, cc_b, 1'b0, rd, er);
    chk("dr_read_data", rd, exp);
    chk("dr_read_slverr", 32'(er), 32'd0);
    if (rxq.size() != 0) void'(rxq.pop_front());
    if (cc_rx) begin
      if (rxq.size() < DEPTH) rxq.push_back(cc_b);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic rx_push(input byte unsigned b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
    if (rxq.size() < DEPTH) rxq.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic tx_pop_chk();
    chk("tx_valid", 32'(tx_valid), 32'd1);
    chk("tx_data", 32'(tx_data), 32'(txq[0]));
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    void'(txq.pop_front());
  endtask

  task automatic chk_stat(input string tag);
    reg_rd(A_ST, m_stat(), tag);
  endtask

  task automatic chk_irq(input string tag);
    tick();
    chk(tag, 32'(irq), 32'(m_irq()));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    byte unsigned b;
    logic [15:0] dv;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    m_reset();
    tick(3);
    chk("rst_ready", 32'(pready), 32'd0);
    chk("rst_slverr", 32'(pslverr), 32'd0);
    chk("rst_rdata", prdata, 32'd0);
    chk("rst_dlr", 32'(dlr), 32'd1);
    chk("rst_lcr", 32'(lcr), 32'd0);
    chk("rst_loop", 32'(loop_o), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    rst = 1'b0;
    tick();
    reg_rd(A_DLR, 32'h1, "dlr_reset");
    reg_rd(A_ST, 32'h0000_0009, "stat_reset");
    chk("irq_after_reset", 32'(irq), 32'd0);

    // TX fill to full, overflow write, drain in order
    for (int i = 0; i < DEPTH; i++) dr_write(8'(8'h41 + i));
    chk_stat("stat_tx_full");
    dr_write(8'($urandom));
    chk_stat("stat_tx_after_overflow");
    for (int i = 0; i < DEPTH; i++) tx_pop_chk();
    chk("tx_valid_drained", 32'(tx_valid), 32'd0);

    // RX overrun and its interrupt
    for (int i = 0; i <= DEPTH; i++) rx_push(8'($urandom));
    chk_stat("stat_rx_overrun");
    reg_wr(A_IER, 32'h4, "ier_elsi"); m_ier = 3'h4;
    chk_irq("irq_overrun");
    reg_wr(A_ST, 32'h4, "stat_w1c"); m_ovr = 1'b0;
    chk_irq("irq_overrun_cleared");
    chk_stat("stat_after_w1c");
    for (int i = 0; i <= DEPTH; i++) dr_read(1'b0, 8'h00);

    // RX threshold T=8
    reg_wr(A_IER, 32'h1, "ier_erbi"); m_ier = 3'h1;
    reg_wr(A_FCR, 32'h2, "fcr_thr2"); m_rxthr = 2'd2;
    for (int i = 0; i < 7; i++) rx_push(8'($urandom));
    chk_irq("irq_below_thr");
    rx_push(8'($urandom));
    chk("irq_latency", 32'(irq), 32'd0);
    chk_irq("irq_at_thr");
    dr_read(1'b0, 8'h00);
    chk_irq("irq_after_pop");

    // Full RX with simultaneous pop and push, across pointer wrap
    while (rxq.size() < DEPTH) rx_push(8'($urandom));
    chk_stat("stat_rx_full_again");
    dr_read(1'b1, 8'($urandom));
    chk_stat("stat_pop_push_full");
    for (int i = 0; i < DEPTH; i++) dr_read(1'b0, 8'h00);

    // Flush both FIFOs while the core pushes and pops
    for (int i = 0; i < 3; i++) dr_write(8'($urandom));
    for (int i = 0; i < 3; i++) rx_push(8'($urandom));
    apb(A_FCR, 1'b1, 32'hC, 1'b1, 8'($urandom), 1'b1, rd, er);
    chk("fcr_flush_slverr", 32'(er), 32'd0);
    rxq.delete(); txq.delete(); m_rxthr = 2'd0;
    chk_stat("stat_after_flush");
    reg_rd(A_FCR, 32'h0, "fcr_readback");
    dr_read(1'b0, 8'h00);

    // Decode errors
    apb(BASE + 32'h18, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, rd, er);
    chk("err_offset_slverr", 32'(er), 32'd1);
    chk("err_offset_rdata", rd, 32'd0);
    apb(32'ha0310004, 1'b0, 32'h0, 1'b0, 8'h00, 1'b0, rd, er);
    chk("err_base_slverr", 32'(er), 32'd1);
    apb(BASE + 32'h06, 1'b1, 32'h7, 1'b0, 8'h00, 1'b0, rd, er);
    chk("err_align_slverr", 32'(er), 32'd1);
    reg_rd(A_IER, {29'h0, m_ier}, "ier_unchanged");

    // LCR/loop and DLR
    b = 8'($urandom) & 8'hFE;
    reg_wr(A_LCR, {23'h0, 1'b1, b}, "lcr_write");
    chk("lcr_out", 32'(lcr), 32'(b));
    chk("loop_out", 32'(loop_o), 32'd1);
    reg_rd(A_LCR, {23'h0, 1'b1, b}, "lcr_readback");
    reg_wr(A_DLR, 32'h0, "dlr_zero");
    reg_rd(A_DLR, 32'h1, "dlr_zero_readback");
    dv = 16'($urandom_range(1, 65535));
    reg_wr(A_DLR, {16'h0, dv}, "dlr_write");
    chk("dlr_out", 32'(dlr), 32'(dv));

    // TX-empty interrupt
    reg_wr(A_IER, 32'h2, "ier_etbei"); m_ier = 3'h2;
    chk_irq("irq_tx_empty");
    dr_write(8'($urandom));
    chk_irq("irq_tx_nonempty");
    tx_pop_chk();
    chk_irq("irq_tx_empty_again");

    // psel dropped during the wait cycle: no side effect
    psel = 1'b1; penable = 1'b1; paddr = A_IER; pwrite = 1'b1; pwdata = 32'h7;
    tick();
    chk("abort_wait_ready", 32'(pready), 32'd0);
    psel = 1'b0; penable = 1'b0;
    tick(2);
    chk("abort_idle_ready", 32'(pready), 32'd0);
    reg_rd(A_IER, {29'h0, m_ier}, "ier_after_abort");

    // Reset in the middle of a transfer
    reg_wr(A_DLR, 32'h55, "dlr_pre_reset");
    psel = 1'b1; penable = 1'b1; paddr = A_ST; pwrite = 1'b0;
    tick();
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    #1;
    chk("midreset_ready", 32'(pready), 32'd0);
    tick();
    rst = 1'b0;
    m_reset();
    tick();
    reg_rd(A_DLR, 32'h1, "dlr_after_midreset");
    chk_stat("stat_after_midreset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
